// File: rtl/jtlabrun_prog_pkg.sv
// Shared types and constants for the Labyrinth Runner download loader.
package jtlabrun_prog_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned PROM_SIZE = 1024;
  localparam int unsigned ENTRY_W   = 22 + 8 + 2;

  // Active-low lane enables: even byte writes the low lane, odd the high lane
  localparam logic [1:0] MASK_LO = 2'b10;
  localparam logic [1:0] MASK_HI = 2'b01;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } entry_t;

endpackage

// File: rtl/jtlabrun_prog_fifo.sv
// Two-entry FIFO holding pending SDRAM byte writes; push and pop may coincide.
module jtlabrun_prog_fifo
  import jtlabrun_prog_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_data,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_data,
  output logic               o_full,
  output logic               o_empty
);

  logic [ENTRY_W-1:0] r_mem [2];
  logic               r_wp;
  logic               r_rp;
  logic [1:0]         r_cnt;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_cnt == 2'd2);
  assign o_empty   = (r_cnt == 2'd0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rp];

  // Storage array, written on an accepted push
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp] <= i_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wp <= ~r_wp;
      if (w_do_pop)  r_rp <= ~r_rp;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/jtlabrun_prog_loader.sv
// ioctl download stream to SDRAM byte writes and colour PROM writes.
module jtlabrun_prog_loader
  import jtlabrun_prog_pkg::*;
#(
  parameter logic [21:0] PROM_START = 22'h6_0000,
  parameter int unsigned PROM_AW    = $clog2(PROM_SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               downloading,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  input  logic               ioctl_wr,
  output logic [21:0]        prog_addr,
  output logic [7:0]         prog_data,
  output logic [1:0]         prog_mask,
  output logic               prog_we,
  input  logic               sdram_ack,
  output logic               prom_we,
  output logic [PROM_AW-1:0] prom_addr,
  output logic [3:0]         prom_data,
  output logic               dwnld_busy,
  output logic               ovf
);

  logic [24:0]        w_prom_base;
  logic [24:0]        w_prom_end;
  logic               w_accept;
  logic               w_is_sdram;
  logic               w_is_prom;
  logic [PROM_AW-1:0] w_prom_off;
  entry_t             w_push_entry;
  entry_t             w_head;
  logic [ENTRY_W-1:0] w_fifo_dout;
  logic               w_full;
  logic               w_empty;
  logic               w_load;
  logic               w_drop;
  state_t             r_state;
  state_t             w_state_nxt;

  logic [21:0]        r_prog_addr;
  logic [7:0]         r_prog_data;
  logic [1:0]         r_prog_mask;
  logic               r_prog_we;
  logic               r_prom_we;
  logic [PROM_AW-1:0] r_prom_addr;
  logic [3:0]         r_prom_data;
  logic               r_ovf;
  logic               r_dl_d;

  assign w_prom_base = {3'b000, PROM_START};
  assign w_prom_end  = w_prom_base + (25'd1 << PROM_AW);
  assign w_accept    = ioctl_wr & downloading;
  assign w_is_sdram  = w_accept & (ioctl_addr < w_prom_base);
  assign w_is_prom   = w_accept & (ioctl_addr >= w_prom_base) & (ioctl_addr < w_prom_end);
  assign w_prom_off  = ioctl_addr[PROM_AW-1:0] - PROM_START[PROM_AW-1:0];

  assign w_push_entry.addr = ioctl_addr[22:1];
  assign w_push_entry.data = ioctl_dout;
  assign w_push_entry.mask = ioctl_addr[0] ? MASK_HI : MASK_LO;
  assign w_head            = entry_t'(w_fifo_dout);

  // The head is popped as it is copied into the request registers, so the
  // request in flight plus two buffered bytes can be pending at once.
  assign w_drop = w_is_sdram & w_full & ~w_load;

  jtlabrun_prog_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_is_sdram),
    .i_data  (w_push_entry),
    .i_pop   (w_load),
    .o_data  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Write FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Write FSM next state and load strobe
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_load      = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ:     if (sdram_ack) w_state_nxt = GAP;
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // SDRAM request registers, held stable until acknowledged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prog_addr <= '0;
      r_prog_data <= '0;
      r_prog_mask <= '0;
      r_prog_we   <= 1'b0;
    end else if (w_load) begin
      r_prog_addr <= w_head.addr;
      r_prog_data <= w_head.data;
      r_prog_mask <= w_head.mask;
      r_prog_we   <= 1'b1;
    end else if (r_state == REQ && sdram_ack) begin
      r_prog_we   <= 1'b0;
    end
  end

  // PROM write path, one cycle after the byte is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prom_we   <= 1'b0;
      r_prom_addr <= '0;
      r_prom_data <= '0;
    end else begin
      r_prom_we <= w_is_prom;
      if (w_is_prom) begin
        r_prom_addr <= w_prom_off;
        r_prom_data <= ioctl_dout[3:0];
      end
    end
  end

  // Sticky overflow flag, cleared when a new download window opens
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_dl_d <= 1'b0;
    end else begin
      r_dl_d <= downloading;
      if (w_drop)                      r_ovf <= 1'b1;
      else if (downloading && !r_dl_d) r_ovf <= 1'b0;
    end
  end

  assign prog_addr  = r_prog_addr;
  assign prog_data  = r_prog_data;
  assign prog_mask  = r_prog_mask;
  assign prog_we    = r_prog_we;
  assign prom_we    = r_prom_we;
  assign prom_addr  = r_prom_addr;
  assign prom_data  = r_prom_data;
  assign ovf        = r_ovf;
  assign dwnld_busy = downloading | ~w_empty | (r_state != IDLE);

endmodule

// File: tb/tb_jtlabrun_prog_loader.sv
// Scoreboard bench for the download loader: directed scenarios plus random traffic.
module tb_jtlabrun_prog_loader;

  localparam logic [24:0] PSTART = 25'h06_0000;
  localparam logic [24:0] PEND   = 25'h06_0400;

  typedef struct packed {
    logic [21:0] a;
    logic [7:0]  d;
    logic [1:0]  m;
  } sd_t;

  typedef struct packed {
    logic [9:0] a;
    logic [3:0] d;
  } pr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wr = 1'b0;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        sdram_ack;
  logic        prom_we;
  logic [9:0]  prom_addr;
  logic [3:0]  prom_data;
  logic        dwnld_busy;
  logic        ovf;

  logic        auto_ack = 1'b0;
  logic        ack_auto = 1'b0;
  logic        ack_man  = 1'b0;
  assign sdram_ack = auto_ack ? ack_auto : ack_man;

  int n_checks = 0;
  int n_fail   = 0;
  int n_issued = 0;
  int n_acked  = 0;
  sd_t sdq[$];
  pr_t prq[$];

  jtlabrun_prog_loader #(.PROM_START(22'h6_0000), .PROM_AW(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_we     (prog_we),
    .sdram_ack   (sdram_ack),
    .prom_we     (prom_we),
    .prom_addr   (prom_addr),
    .prom_data   (prom_data),
    .dwnld_busy  (dwnld_busy),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: what a byte should turn into, from the address map rules
  task automatic issue(input logic [24:0] a, input logic [7:0] d, input bit drop);
    sd_t s;
    pr_t p;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (downloading) begin
      if (a < PSTART) begin
        if (!drop) begin
          s.a = a[22:1];
          s.d = d;
          s.m = (a % 2 == 1) ? 2'b01 : 2'b10;
          sdq.push_back(s);
          n_issued++;
        end
      end else if (a < PEND) begin
        p.a = 10'(a - PSTART);
        p.d = d[3:0];
        prq.push_back(p);
      end
    end
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
  endtask

  // Count acknowledges the DUT actually accepts (request pending and ack high)
  always @(posedge clk) begin
    if (!rst && prog_we && sdram_ack) n_acked++;
  end

  // Random acknowledge driver; also pulses ack while no request is pending
  int wait_cnt = 0;
  always @(negedge clk) begin
    if (auto_ack) begin
      if (prog_we) begin
        if (wait_cnt == 0) begin
          ack_auto = 1'b1;
          wait_cnt = $urandom_range(0, 3);
        end else begin
          ack_auto = 1'b0;
          wait_cnt--;
        end
      end else begin
        ack_auto = ($urandom_range(0, 7) == 0);
      end
    end else begin
      ack_auto = 1'b0;
    end
  end

  // Monitor: compare every new SDRAM request and every PROM strobe against the queues
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    sd_t es;
    pr_t ep;
    if (!rst) begin
      if (prog_we && !prev_we) begin
        if (sdq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_prog_we: got addr 0x%0h, expected no request", prog_addr);
        end else begin
          es = sdq.pop_front();
          check("prog_addr", 32'(prog_addr), 32'(es.a));
          check("prog_data", 32'(prog_data), 32'(es.d));
          check("prog_mask", 32'(prog_mask), 32'(es.m));
        end
      end
      if (prom_we) begin
        if (prq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_prom_we: got addr 0x%0h, expected no strobe", prom_addr);
        end else begin
          ep = prq.pop_front();
          check("prom_addr", 32'(prom_addr), 32'(ep.a));
          check("prom_data", 32'(prom_data), 32'(ep.d));
        end
      end
    end
    prev_we = prog_we;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    int  acks;
    bit  ok_busy;
    bit  done;
    int  budget;
    logic [24:0] ra;

    // Reset state
    #5;
    check("rst_prog_we", 32'(prog_we), 0);
    check("rst_prog_fields", {prog_addr, prog_data, prog_mask}, 0);
    check("rst_prom", {prom_we, prom_addr, prom_data}, 0);
    check("rst_busy_ovf", {dwnld_busy, ovf}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single SDRAM byte, ack three cycles after the request
    downloading = 1'b1;
    issue(25'h3, 8'hA5, 0);
    check("lat_we_early", 32'(prog_we), 0);
    @(posedge clk); #1;
    check("lat_we_2cyc", 32'(prog_we), 1);
    check("single_fields", {prog_addr, prog_data, prog_mask}, {22'h1, 8'hA5, 2'b01});
    repeat (2) @(posedge clk);
    @(negedge clk); ack_man = 1'b1;
    @(posedge clk); #1; ack_man = 1'b0;
    check("we_fall_after_ack", 32'(prog_we), 0);
    repeat (2) @(posedge clk); #1;

    // PROM byte
    issue(25'h6_0005, 8'h3C, 0);
    check("prom_pulse", {prom_we, prom_addr, prom_data}, {1'b1, 10'd5, 4'hC});
    check("prom_no_prog", 32'(prog_we), 0);
    @(posedge clk); #1;
    check("prom_one_cycle", 32'(prom_we), 0);
    @(posedge clk); #1;
    check("prom_no_prog_late", 32'(prog_we), 0);

    // Overflow: three bytes fit, the fourth is dropped
    issue(25'h10, 8'h11, 0);
    issue(25'h11, 8'h22, 0);
    issue(25'h12, 8'h33, 0);
    issue(25'h13, 8'h44, 1);
    check("ovf_set", 32'(ovf), 1);
    repeat (20) @(posedge clk); #1;
    check("req_held", {prog_we, prog_addr, prog_mask}, {1'b1, 22'h8, 2'b10});

    // Download window closes with two bytes still buffered
    downloading = 1'b0;
    acks = 0; ok_busy = 1; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      ack_man = prog_we;
      @(posedge clk); #1;
      if (ack_man) acks++;
      ack_man = 1'b0;
      if (acks == 3) done = 1;
      else if (!dwnld_busy) ok_busy = 0;
    end
    check("drain_acks", 32'(acks), 3);
    check("busy_while_pending", 32'(ok_busy), 1);
    check("busy_in_gap", 32'(dwnld_busy), 1);
    @(posedge clk); #1;
    check("busy_after_gap", 32'(dwnld_busy), 0);
    check("ovf_sticky", 32'(ovf), 1);
    downloading = 1'b1;
    @(posedge clk); #1;
    check("ovf_clear_on_rise", 32'(ovf), 0);

    // Out-of-range byte and writes outside the download window
    issue(25'h6_0400, 8'h77, 0);
    check("oor_no_prom", 32'(prom_we), 0);
    @(posedge clk); #1;
    check("oor_no_prog", 32'(prog_we), 0);
    downloading = 1'b0;
    issue(25'h5, 8'h55, 0);
    issue(25'h6_0001, 8'h66, 0);
    check("idle_no_prom", 32'(prom_we), 0);
    @(posedge clk); #1;
    check("idle_no_prog", {prog_we, dwnld_busy}, 0);

    // Random traffic, throttled so the buffer can never overflow
    downloading = 1'b1;
    auto_ack = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6)      ra = 25'($urandom_range(0, 32'h5_FFFF));
      else if (r < 9) ra = PSTART + 25'($urandom_range(0, 1023));
      else            ra = PEND + 25'($urandom_range(0, 32'hFF_FFFF));
      if (ra < PSTART) begin
        budget = 0;
        while ((n_issued - n_acked) >= 2 && budget < 100) begin
          @(posedge clk); #1;
          budget++;
        end
        if (budget >= 100) begin
          n_checks++; n_fail++;
          $display("FAIL rand_throttle: got %0d pending, expected drain", n_issued - n_acked);
        end
      end
      issue(ra, 8'($urandom), 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    downloading = 1'b0;
    budget = 0;
    while (dwnld_busy && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    check("rand_drained", 32'(dwnld_busy), 0);
    @(posedge clk); #1;
    check("rand_sdq_empty", 32'(sdq.size()), 0);
    check("rand_prq_empty", 32'(prq.size()), 0);
    check("rand_no_ovf", 32'(ovf), 0);

    // Asynchronous reset in the middle of a request
    auto_ack = 1'b0;
    downloading = 1'b1;
    @(posedge clk); #1;
    issue(25'h20, 8'h01, 0);
    issue(25'h21, 8'h02, 0);
    issue(25'h22, 8'h03, 0);
    issue(25'h23, 8'h04, 1);
    check("rst_pre_ovf", {prog_we, ovf}, 2'b11);
    @(posedge clk); #3;
    rst = 1'b1;
    downloading = 1'b0;
    #1;
    check("async_rst_we", 32'(prog_we), 0);
    check("async_rst_busy_ovf", {dwnld_busy, ovf}, 0);
    sdq.delete();
    @(negedge clk);
    rst = 1'b0;
    n_issued = n_acked;
    repeat (3) @(posedge clk); #1;
    check("post_rst_empty", {prog_we, dwnld_busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
